// File: rtl/ones_comp_div_pkg.sv
// Shared types and constants for the one's-complement divider.
// Word width comes from NUM_BIT; magnitude excludes the sign bit.
`ifndef NUM_BIT
`define NUM_BIT 15
`endif

package agc_div_pkg;

  localparam int WIDTH  = `NUM_BIT;
  localparam int MAG    = WIDTH - 1;
  localparam int DWIDTH = 2 * WIDTH;
  localparam int CW     = $clog2(MAG);

  typedef enum logic {
    IDLE,
    ITER
  } state_t;

  function automatic logic [WIDTH-1:0] oc_word(
    input logic           sign,
    input logic [MAG-1:0] mag
  );
    return sign ? ~{1'b0, mag} : {1'b0, mag};
  endfunction

endpackage

// File: rtl/ones_comp_div_if.sv
// Sequencer-to-divider bundle: operands/start in, results/flags out.
interface ones_comp_div_if;
  import agc_div_pkg::*;

  logic              start;
  logic [DWIDTH-1:0] dividend;
  logic [WIDTH-1:0]  divisor;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  quotient;
  logic [WIDTH-1:0]  remainder;
  logic              overflow;
  logic              div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder,
    input  overflow, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder,
    output overflow, div_zero
  );

endinterface

// File: rtl/ones_comp_div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract.
module restoring_div_step
  import agc_div_pkg::*;
(
  input  logic [MAG-1:0] r,
  input  logic           bit_in,
  input  logic [MAG-1:0] ym,
  output logic [MAG-1:0] r_next,
  output logic           qbit
);

  logic [MAG:0]   t;
  logic [MAG-1:0] diff;

  // r < ym always holds, so t-ym and a rejected t both fit in MAG bits
  assign t      = {r, bit_in};
  assign qbit   = (t >= {1'b0, ym});
  assign diff   = t[MAG-1:0] - ym;
  assign r_next = qbit ? diff : t[MAG-1:0];

endmodule

// File: rtl/ones_comp_div.sv
// Sequential sign-magnitude restoring divider, one quotient bit per clock.
module ones_comp_div
  import agc_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  ones_comp_div_if.slave  bus
);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [MAG-1:0] r;
  logic [MAG-1:0] l;
  logic [MAG-2:0] q;
  logic [MAG-1:0] ym_q;
  logic           sq_q;
  logic           sr_q;

  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  rem_q;
  logic              ovf_q;
  logic              dz_q;

  logic              sx;
  logic              sy;
  logic              sq;
  logic [DWIDTH-2:0] dm;
  logic [MAG:0]      dm_hi;
  logic [MAG-1:0]    ym;
  logic [MAG-1:0]    r_nx;
  logic              qb;

  assign sx    = bus.dividend[DWIDTH-1];
  assign sy    = bus.divisor[WIDTH-1];
  assign sq    = sx ^ sy;
  assign dm    = sx ? ~bus.dividend[DWIDTH-2:0]
                    : bus.dividend[DWIDTH-2:0];
  assign ym    = sy ? ~bus.divisor[WIDTH-2:0]
                    : bus.divisor[WIDTH-2:0];
  assign dm_hi = dm[DWIDTH-2:MAG];

  restoring_div_step u_step (
    .r      (r),
    .bit_in (l[MAG-1]),
    .ym     (ym_q),
    .r_next (r_nx),
    .qbit   (qb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      r      <= '0;
      l      <= '0;
      q      <= '0;
      ym_q   <= '0;
      sq_q   <= 1'b0;
      sr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            // quotient would need more than MAG bits: saturate at once
            if (ym == '0 || dm_hi >= {1'b0, ym}) begin
              dz_q   <= (ym == '0);
              ovf_q  <= 1'b1;
              quo_q  <= oc_word(sq, '1);
              rem_q  <= '0;
              done_q <= 1'b1;
            end else begin
              r      <= dm_hi[MAG-1:0];
              l      <= dm[MAG-1:0];
              ym_q   <= ym;
              sq_q   <= sq;
              sr_q   <= sx;
              cnt    <= CW'(MAG - 1);
              ovf_q  <= 1'b0;
              dz_q   <= 1'b0;
              busy_q <= 1'b1;
              state  <= ITER;
            end
          end
        end
        ITER: begin
          r <= r_nx;
          q <= {q[MAG-3:0], qb};
          l <= {l[MAG-2:0], 1'b0};
          if (cnt == '0) begin
            quo_q  <= oc_word(sq_q, {q, qb});
            rem_q  <= oc_word(sr_q, r_nx);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.overflow  = ovf_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_ones_comp_div.sv
// Scoreboard bench for ones_comp_div: arithmetic model, latency, busy.
module tb_ones_comp_div;
  import agc_div_pkg::*;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             ov;
    logic             dz;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ones_comp_div_if bus ();

  ones_comp_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] enc(input logic s,
                                           input longint mag);
    logic [WIDTH-1:0] m;
    m = WIDTH'(mag);
    return s ? ~m : m;
  endfunction

  function automatic exp_t model(input logic [DWIDTH-1:0] dvd,
                                 input logic [WIDTH-1:0] dvs);
    exp_t              e;
    logic [DWIDTH-2:0] tm;
    logic [WIDTH-2:0]  ty;
    longint            dm, ym, qv, maxq;
    logic              sx, sq;
    sx   = dvd[DWIDTH-1];
    sq   = sx ^ dvs[WIDTH-1];
    tm   = sx ? ~dvd[DWIDTH-2:0] : dvd[DWIDTH-2:0];
    ty   = dvs[WIDTH-1] ? ~dvs[WIDTH-2:0] : dvs[WIDTH-2:0];
    dm   = longint'(tm);
    ym   = longint'(ty);
    maxq = (longint'(1) << MAG) - 1;
    e.acc = 0;
    e.dz  = (ym == 0);
    qv    = e.dz ? 0 : dm / ym;
    e.ov  = e.dz || (qv > maxq);
    if (e.ov) begin
      e.q = enc(sq, maxq);
      e.r = '0;
    end else begin
      e.q = enc(sq, qv);
      e.r = enc(sx, dm % ym);
    end
    return e;
  endfunction

  // latency: edges from the accepting edge up to the one raising done
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (!bus.busy && !bus.done) busy_cnt = 0;
      if (bus.done) begin
        chk("done_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("quotient", bus.quotient, e.q);
          chk("remainder", bus.remainder, e.r);
          chk("overflow", bus.overflow, e.ov);
          chk("div_zero", bus.div_zero, e.dz);
          chk("latency", cyc - e.acc, e.ov ? 1 : MAG + 1);
          chk("busy_cycles", busy_cnt, e.ov ? 0 : MAG);
        end
        busy_cnt = 0;
      end
    end
  end

  // call at a negedge; returns one negedge after the accepting edge
  task automatic start_op(input logic [DWIDTH-1:0] dvd,
                          input logic [WIDTH-1:0] dvs,
                          input bit push);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    if (push) begin
      e = model(dvd, dvs);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = DWIDTH'({$urandom, $urandom});
    bus.divisor  = WIDTH'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!bus.done && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", bus.done, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_q"}, bus.quotient, 0);
    chk({tag, "_r"}, bus.remainder, 0);
    chk({tag, "_ov"}, bus.overflow, 0);
    chk({tag, "_dz"}, bus.div_zero, 0);
  endtask

  initial begin
    logic [DWIDTH-1:0] dvd;
    logic [WIDTH-1:0]  dvs;
    int                k;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    start_op(30'h0000_4000, 15'h0003, 1);
    wait_done(40);
    @(negedge clk);
    start_op(30'h3FFF_BFFF, 15'h0003, 1);
    wait_done(40);
    @(negedge clk);
    start_op(30'h0000_4000, 15'h7FFC, 1);
    wait_done(40);
    start_op(30'h0000_4000, 15'h0003, 1);
    repeat (3) @(negedge clk);
    chk("hold_q", bus.quotient, 15'h6AAA);
    chk("hold_busy", bus.busy, 1);
    wait_done(40);
    @(negedge clk);
    start_op(30'h0001_4000, 15'h0003, 1);
    wait_done(40);
    @(negedge clk);
    start_op(30'h0000_4000, 15'h7FFF, 1);
    wait_done(40);
    @(negedge clk);
    start_op(30'h0000_4000, 15'h0000, 1);
    wait_done(40);
    @(negedge clk);

    start_op(30'h0000_4000, 15'h0003, 1);
    repeat (3) @(negedge clk);
    start_op(30'h3FFF_F000, 15'h0005, 0);
    wait_done(40);
    @(negedge clk);

    start_op(30'h0000_4000, 15'h0003, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    repeat (25) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      dvd = DWIDTH'({$urandom, $urandom});
      dvd[DWIDTH-2:0] = dvd[DWIDTH-2:0] >> $urandom_range(0, 16);
      dvs = WIDTH'($urandom);
      if (i % 9 == 4) dvs[WIDTH-2:0] = '0;
      start_op(dvd, dvs, 1);
      wait_done(40);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ones_comp_div.md
Name: ones_comp_div

Overview:
Sequential one's-complement divider, the inverse of the ALU multiplier. It takes a double-width one's-complement dividend (the multiplier's product format) and a single-width one's-complement divisor. It returns a single-width quotient and remainder, both one's complement, plus overflow and divide-by-zero flags. It uses sign-magnitude restoring division at one quotient bit per clock, with a start/busy/done handshake toward the ALU sequencer.

Parameters:
WIDTH, `NUM_BIT (15), word width including sign bit; magnitude width MAG = WIDTH-1 (14).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  2*WIDTH  one's-complement dividend; sign at bit 2*WIDTH-1
divisor  input  WIDTH  one's-complement divisor; sign at bit WIDTH-1
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: results valid
quotient  output  WIDTH  one's-complement quotient, held until next accepted start
remainder  output  WIDTH  one's-complement remainder, held until next accepted start
overflow  output  1  quotient magnitude would exceed MAG bits; held with results
div_zero  output  1  divisor is +0 or -0; held with results

Behaviour:
- Reset (rst=1 at an edge): state IDLE, counter 0, and busy, done, quotient, remainder, overflow, div_zero all 0. Reset mid-operation aborts immediately; no done is produced.
- Sign and magnitude extraction:
  - sx = dividend[2W-1]; dividend magnitude DM (2W-1 bits) = sx ? ~dividend[2W-2:0] : dividend[2W-2:0].
  - sy = divisor[W-1]; divisor magnitude YM (MAG bits) = sy ? ~divisor[W-2:0] : divisor[W-2:0].
  - Quotient sign sq = sx^sy. Remainder sign sr = sx.
- FSM has two states: IDLE and ITER. busy = (state==ITER).
- IDLE with start=1 (edge E0):
  - If YM==0: div_zero=1, overflow=1, quotient = sq ? ~{0,all-ones MAG} : {0,all-ones MAG}, remainder=+0 (all zero), done=1. Stay in IDLE.
  - Else if DM[2W-2:MAG] >= YM (zero-extended compare): overflow=1, div_zero=0, quotient saturated exactly as for divide-by-zero, remainder=+0, done=1. Stay in IDLE.
  - Else: load partial remainder R (MAG+1 bits) = DM[2W-2:MAG] and low shift register L = DM[MAG-1:0]. Latch sq, sr, YM. Counter = MAG-1. Clear overflow and div_zero. Go to ITER.
- ITER, one edge per quotient bit, MSB first:
  - T = {R[MAG-1:0], L[MAG-1]}.
  - If T >= YM: R = T-YM and qbit = 1. Otherwise R = T and qbit = 0.
  - Shift qbit into Q; shift L left.
  - When counter==0: quotient = sq ? ~{0,Q} : {0,Q} and remainder = sr ? ~{0,R[MAG-1:0]} : {0,R[MAG-1:0]}, done=1, go to IDLE. Otherwise decrement the counter.
- Latency: normal operation gives done on the MAG-th edge after E0 (14 cycles). Overflow and divide-by-zero give done after E0 (1 cycle).
- done is high for exactly one cycle. A start during that cycle is accepted (back-to-back operation).
- start while busy=1 is ignored. Operand inputs are don't-care except at the accepting edge.
- Negative-zero results are legal and not normalised. A zero magnitude with negative sign yields all ones.
- Outputs change only at reset, at an overflow/divide-by-zero accept, or at the final ITER edge. Outputs are not cleared at the start of a normal operation.

Decomposition:
- Package agc_div_pkg holds: the state enum (IDLE, ITER), localparams MAG and DWIDTH = 2*WIDTH, and a function returning sign-applied one's-complement encoding.
- One combinational sub-module, restoring_div_step: inputs R, next dividend bit, and YM; outputs new R and qbit. It is instantiated once, and the FSM reuses it every cycle.

Test Plan:
- Positive division: dividend=30'h0000_4000, divisor=15'h0003, start 1 cycle -> busy 14 cycles; done with quotient=15'h1555, remainder=15'h0001, overflow=0, div_zero=0.
- Negative dividend: dividend=30'h3FFF_BFFF, divisor=15'h0003 -> quotient=15'h6AAA, remainder=15'h7FFE (-1).
- Negative divisor: dividend=30'h0000_4000, divisor=15'h7FFC -> quotient=15'h6AAA, remainder=15'h0001. Then start again in the done cycle with divisor=15'h0003 -> accepted; second done gives quotient=15'h1555.
- Overflow: dividend=30'h0001_4000 (high magnitude 5), divisor=15'h0003 -> done 1 cycle after start, overflow=1, quotient=15'h3FFF, remainder=15'h0000, busy never asserted.
- Divide by -0: dividend=30'h0000_4000, divisor=15'h7FFF -> done after 1 cycle, div_zero=1, overflow=1, quotient=15'h4000.
- Reset mid-op plus ignored start: start a normal divide; at cycle 5 pulse start with other operands -> ignored. At cycle 7 assert rst -> next cycle all outputs 0, busy=0, and no done is ever seen for the aborted operation.
